risc_datapath: RTL and testbench

- 32-bit single-bus RISC datapath: 16 GPRs, Hi/Lo, PC, IR, MAR, MDR, Y, 64-bit Z, ALU, 512x32 unified memory, output port, select/encode logic and a branch-condition (CON) flip-flop.
- Every transfer is driven cycle by cycle by an external control unit or testbench through per-register In/Out strobes.
- Only the CON flag and the output port leave the block.

---
 rtl/risc_datapath.sv | 244 ++++++++++++++++++++++++
 tb/tb_risc_datapath.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_datapath.sv
// ---------------------------------------------------------------------------
// risc_datapath
//   32-bit single-bus RISC datapath. Every register transfer is sequenced
//   externally through per-register load (xxIn) and bus-drive (xxOut)
//   strobes. Only the branch-condition flag and the output port are visible
//   outside the block.
//
// Ports
//   clock, clear         rising-edge clock, asynchronous active-low reset
//   HiIn..IRIn           register load strobes (sampled on the clock edge)
//   HiOut..COut          bus-drive strobes, priority-resolved onto the bus
//   IPortInput           input-port word, driven onto the bus by IPortOut
//   Gra/Grb/Grc          pick the IR Ra/Rb/Rc field as GPR address
//   RIn/ROut/BAOut       GPR load / drive / base-address drive (R0 reads 0)
//   Conin, ConOut        CON flip-flop load strobe and value
//   memread/memwrite     MDR-from-memory select / MDR-to-memory write
//   ALUCode              ALU operation, A = Y, B = bus
//   initMem              direct bus-to-memory write (beats memwrite)
//   OutPort              output-port register
//
// Handshake: there is none. Strobes are plain level controls sampled on the
// rising edge; the sequencer is responsible for asserting at most the
// sources it wants, ties on the bus are resolved by a fixed priority.
// ---------------------------------------------------------------------------
module risc_datapath #(
    parameter int    MEM_DEPTH     = 512,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        HiIn,
    input  logic        LoIn,
    input  logic        ZIn,
    input  logic        PCIn,
    input  logic        MDRIn,
    input  logic        MARIn,
    input  logic        YIn,
    input  logic        OPortIn,
    input  logic        IRIn,
    input  logic        HiOut,
    input  logic        LoOut,
    input  logic        ZHiOut,
    input  logic        ZLoOut,
    input  logic        PCOut,
    input  logic        MDROut,
    input  logic        IPortOut,
    input  logic        COut,
    input  logic [31:0] IPortInput,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        RIn,
    input  logic        ROut,
    input  logic        BAOut,
    input  logic        Conin,
    output logic        ConOut,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [4:0]  ALUCode,
    input  logic        initMem,
    output logic [31:0] OutPort
);

    localparam int AW = $clog2(MEM_DEPTH);

    // ALU operation codes
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_SHR  = 5'b00111;
    localparam logic [4:0] ALU_SHRA = 5'b01000;
    localparam logic [4:0] ALU_SHL  = 5'b01001;
    localparam logic [4:0] ALU_ROR  = 5'b01010;
    localparam logic [4:0] ALU_ROL  = 5'b01011;
    localparam logic [4:0] ALU_MUL  = 5'b01110;
    localparam logic [4:0] ALU_DIV  = 5'b01111;
    localparam logic [4:0] ALU_NEG  = 5'b10000;
    localparam logic [4:0] ALU_NOT  = 5'b10001;
    localparam logic [4:0] ALU_INCB = 5'b11111;

    // Architectural registers
    logic [31:0] r_gpr [16];
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_mar;
    logic [31:0] r_mdr;
    logic [31:0] r_y;
    logic [63:0] r_z;
    logic        r_con;
    logic [31:0] r_oport;
    logic [31:0] r_mem [MEM_DEPTH];

    // Combinational nets
    logic [31:0]        w_bus;
    logic [3:0]         w_sel;
    logic [31:0]        w_gpr_q;
    logic [31:0]        w_ba_q;
    logic [31:0]        w_csext;
    logic [AW-1:0]      w_addr;
    logic [31:0]        w_mem_q;
    logic               w_cond;
    logic [4:0]         w_shamt;
    logic [31:0]        w_ror;
    logic [31:0]        w_rol;
    logic signed [63:0] w_prod;
    logic signed [31:0] w_quo;
    logic signed [31:0] w_rem;
    logic [63:0]        w_alu;
    logic               w_unused_bits;

    // Opcode and the MAR bits above the memory index are not consumed here.
    assign w_unused_bits = ^{r_ir[31:27], r_mar[31:AW]};

    // Memory image: zero everywhere at elaboration.
    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] = '0;
    end

    // ---------------- select / encode ----------------
    always_comb begin
        w_sel = 4'd0;
        if (Gra)      w_sel = r_ir[26:23];
        else if (Grb) w_sel = r_ir[22:19];
        else if (Grc) w_sel = r_ir[18:15];
    end

    assign w_gpr_q = r_gpr[w_sel];
    // Base-address reads treat R0 as a hardwired zero so "0(Rb)" addressing
    // works without reserving R0 as a constant register.
    assign w_ba_q  = (w_sel == 4'd0) ? 32'd0 : r_gpr[w_sel];
    assign w_csext = {{13{r_ir[18]}}, r_ir[18:0]};

    // ---------------- bus ----------------
    always_comb begin
        w_bus = 32'd0;
        if (IPortOut)    w_bus = IPortInput;
        else if (COut)   w_bus = w_csext;
        else if (MDROut) w_bus = r_mdr;
        else if (PCOut)  w_bus = r_pc;
        else if (ZHiOut) w_bus = r_z[63:32];
        else if (ZLoOut) w_bus = r_z[31:0];
        else if (HiOut)  w_bus = r_hi;
        else if (LoOut)  w_bus = r_lo;
        else if (ROut)   w_bus = w_gpr_q;
        else if (BAOut)  w_bus = w_ba_q;
    end

    // ---------------- memory read ----------------
    assign w_addr  = r_mar[AW-1:0];
    assign w_mem_q = r_mem[w_addr];

    // ---------------- branch condition ----------------
    always_comb begin
        w_cond = 1'b0;
        case (r_ir[20:19])
            2'b00: w_cond = (w_bus == 32'd0);
            2'b01: w_cond = (w_bus != 32'd0);
            2'b10: w_cond = ~w_bus[31];
            2'b11: w_cond = w_bus[31];
            default: w_cond = 1'b0;
        endcase
    end

    // ---------------- ALU ----------------
    assign w_shamt = w_bus[4:0];
    // A shift by 32 (amount 0 on the complementary side) yields 0, so the
    // OR leaves the unrotated word intact.
    assign w_ror   = (r_y >> w_shamt) | (r_y << (6'd32 - {1'b0, w_shamt}));
    assign w_rol   = (r_y << w_shamt) | (r_y >> (6'd32 - {1'b0, w_shamt}));
    assign w_prod  = $signed({{32{r_y[31]}}, r_y}) * $signed({{32{w_bus[31]}}, w_bus});

    always_comb begin
        w_quo = '0;
        w_rem = '0;
        if (w_bus != 32'd0) begin
            w_quo = $signed(r_y) / $signed(w_bus);
            w_rem = $signed(r_y) % $signed(w_bus);
        end
    end

    always_comb begin
        w_alu = 64'd0;
        case (ALUCode)
            ALU_ADD:  w_alu = {32'd0, r_y + w_bus};
            ALU_SUB:  w_alu = {32'd0, r_y - w_bus};
            ALU_AND:  w_alu = {32'd0, r_y & w_bus};
            ALU_OR:   w_alu = {32'd0, r_y | w_bus};
            ALU_SHR:  w_alu = {32'd0, r_y >> w_shamt};
            ALU_SHRA: w_alu = {32'd0, $signed(r_y) >>> w_shamt};
            ALU_SHL:  w_alu = {32'd0, r_y << w_shamt};
            ALU_ROR:  w_alu = {32'd0, w_ror};
            ALU_ROL:  w_alu = {32'd0, w_rol};
            ALU_MUL:  w_alu = w_prod;
            ALU_DIV:  w_alu = {w_rem, w_quo};   // zero divisor leaves both 0
            ALU_NEG:  w_alu = {32'd0, 32'd0 - w_bus};
            ALU_NOT:  w_alu = {32'd0, ~w_bus};
            ALU_INCB: w_alu = {32'd0, w_bus + 32'd1};
            default:  w_alu = 64'd0;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_gpr[i] <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_pc    <= 32'd0;
            r_ir    <= 32'd0;
            r_mar   <= 32'd0;
            r_mdr   <= 32'd0;
            r_y     <= 32'd0;
            r_z     <= 64'd0;
            r_con   <= 1'b0;
            r_oport <= 32'd0;
        end else begin
            if (RIn)     r_gpr[w_sel] <= w_bus;
            if (HiIn)    r_hi    <= w_bus;
            if (LoIn)    r_lo    <= w_bus;
            if (ZIn)     r_z     <= w_alu;
            if (PCIn)    r_pc    <= w_bus;
            if (MDRIn)   r_mdr   <= memread ? w_mem_q : w_bus;
            if (MARIn)   r_mar   <= w_bus;
            if (YIn)     r_y     <= w_bus;
            if (OPortIn) r_oport <= w_bus;
            if (IRIn)    r_ir    <= w_bus;
            if (Conin)   r_con   <= w_cond;
        end
    end

    // Memory is deliberately outside the reset domain. A same-edge MDR read
    // sees the pre-write word because both sides sample on the same edge.
    always_ff @(posedge clock) begin
        if (initMem)       r_mem[w_addr] <= w_bus;
        else if (memwrite) r_mem[w_addr] <= r_mdr;
    end

    assign ConOut  = r_con;
    assign OutPort = r_oport;

endmodule

// File: tb/tb_risc_datapath.sv
// ---------------------------------------------------------------------------
// tb_risc_datapath
//   Directed bench for risc_datapath. A behavioural model of the register
//   file, memory and ALU tracks every transfer; a compare process checks
//   OutPort and ConOut against it on every falling edge, and hand-computed
//   literal expectations pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_risc_datapath;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT controls ----------------
    logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
    logic [31:0] IPortInput;
    logic        Gra, Grb, Grc, RIn, ROut, BAOut, Conin;
    logic        memread, memwrite, initMem;
    logic [4:0]  ALUCode;
    logic        ConOut;
    logic [31:0] OutPort;

    risc_datapath dut (
        .clock(clock), .clear(clear),
        .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn),
        .MARIn(MARIn), .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn),
        .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
        .PCOut(PCOut), .MDROut(MDROut), .IPortOut(IPortOut), .COut(COut),
        .IPortInput(IPortInput),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut), .BAOut(BAOut),
        .Conin(Conin), .ConOut(ConOut),
        .memread(memread), .memwrite(memwrite),
        .ALUCode(ALUCode), .initMem(initMem),
        .OutPort(OutPort)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit run   = 1'b0;

    // ---------------- behavioural model ----------------
    logic [31:0] m_gpr [16];
    logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y, m_out;
    logic [63:0] m_z;
    logic        m_con;
    logic [31:0] m_mem [int];   // words never written read as zero

    function automatic logic [3:0] model_sel();
        if (Gra) return m_ir[26:23];
        if (Grb) return m_ir[22:19];
        if (Grc) return m_ir[18:15];
        return 4'd0;
    endfunction

    function automatic logic [31:0] model_bus();
        logic [3:0] a;
        a = model_sel();
        if (IPortOut) return IPortInput;
        if (COut)     return m_ir[18] ? {13'h1FFF, m_ir[18:0]} : {13'h0, m_ir[18:0]};
        if (MDROut)   return m_mdr;
        if (PCOut)    return m_pc;
        if (ZHiOut)   return m_z[63:32];
        if (ZLoOut)   return m_z[31:0];
        if (HiOut)    return m_hi;
        if (LoOut)    return m_lo;
        if (ROut)     return m_gpr[a];
        if (BAOut)    return (a == 4'd0) ? 32'd0 : m_gpr[a];
        return 32'd0;
    endfunction

    function automatic logic model_cond(logic [31:0] b);
        case (m_ir[20:19])
            2'd0:    return b == 32'd0;
            2'd1:    return b != 32'd0;
            2'd2:    return b[31] == 1'b0;
            default: return b[31] == 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] model_alu(logic [4:0] code, logic [31:0] a, logic [31:0] b);
        int          n, sa, sb;
        longint      p;
        logic [31:0] t, q, r;
        n  = int'(b[4:0]);
        sa = a;
        sb = b;
        t  = a;
        case (code)
            5'd3:  return {32'd0, a + b};
            5'd4:  return {32'd0, a - b};
            5'd5:  return {32'd0, a & b};
            5'd6:  return {32'd0, a | b};
            5'd7:  return {32'd0, a >> n};
            5'd8:  begin t = sa >>> n; return {32'd0, t}; end
            5'd9:  return {32'd0, a << n};
            5'd10: begin
                for (int i = 0; i < n; i++) t = {t[0], t[31:1]};
                return {32'd0, t};
            end
            5'd11: begin
                for (int i = 0; i < n; i++) t = {t[30:0], t[31]};
                return {32'd0, t};
            end
            5'd14: begin p = longint'(sa) * longint'(sb); return p; end
            5'd15: begin
                if (sb == 0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            5'd16: return {32'd0, 32'd0 - b};
            5'd17: return {32'd0, ~b};
            5'd31: return {32'd0, b + 32'd1};
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gpr[i] = 32'd0;
        m_hi = 0; m_lo = 0; m_pc = 0; m_ir = 0; m_mar = 0;
        m_mdr = 0; m_y = 0; m_out = 0; m_z = 0; m_con = 0;
    endtask

    always @(posedge clock or negedge clear) begin : model_upd
        logic [31:0] b, mq;
        logic [63:0] zn;
        logic        cn;
        logic [3:0]  a;
        int          k;
        if (!clear) begin
            model_reset();
        end else begin
            // everything below is computed from pre-edge state
            b  = model_bus();
            a  = model_sel();
            k  = int'(m_mar[8:0]);
            mq = m_mem.exists(k) ? m_mem[k] : 32'd0;
            zn = model_alu(ALUCode, m_y, b);
            cn = model_cond(b);
            if (initMem)       m_mem[k] = b;
            else if (memwrite) m_mem[k] = m_mdr;
            if (MDRIn)   m_mdr = memread ? mq : b;
            if (RIn)     m_gpr[a] = b;
            if (HiIn)    m_hi  = b;
            if (LoIn)    m_lo  = b;
            if (ZIn)     m_z   = zn;
            if (PCIn)    m_pc  = b;
            if (MARIn)   m_mar = b;
            if (YIn)     m_y   = b;
            if (OPortIn) m_out = b;
            if (IRIn)    m_ir  = b;
            if (Conin)   m_con = cn;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (run) begin
            n_cmp++;
            if (OutPort !== m_out) begin
                n_err++;
                $display("FAIL model_outport t=%0t got %h want %h", $time, OutPort, m_out);
            end
            n_cmp++;
            if (ConOut !== m_con) begin
                n_err++;
                $display("FAIL model_conout t=%0t got %b want %b", $time, ConOut, m_con);
            end
        end
    end

    task automatic expect_eq(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clr_ctl();
        {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn} = '0;
        {HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut} = '0;
        {Gra, Grb, Grc, RIn, ROut, BAOut, Conin} = '0;
        {memread, memwrite, initMem} = '0;
        ALUCode    = 5'd0;
        IPortInput = 32'd0;
    endtask

    // Controls are set 1 time unit after a rising edge; tick applies them on
    // the next rising edge and returns 1 unit after it with strobes idle.
    task automatic tick();
        @(posedge clock);
        #1;
        clr_ctl();
    endtask

    task automatic drive_port(logic [31:0] v);
        IPortOut   = 1'b1;
        IPortInput = v;
    endtask

    // Caller selects the bus source; this latches it into OutPort and checks.
    task automatic out_chk(string name, logic [31:0] exp);
        OPortIn = 1'b1;
        tick();
        expect_eq(name, OutPort, exp);
    endtask

    task automatic fetch();
        PCOut = 1; MARIn = 1; ZIn = 1; ALUCode = 5'b11111; tick();
        ZLoOut = 1; PCIn = 1; memread = 1; MDRIn = 1;      tick();
        MDROut = 1; IRIn = 1;                              tick();
    endtask

    task automatic const_load(string name, logic [31:0] ir, logic [31:0] exp);
        drive_port(ir); IRIn = 1;    tick();
        Gra = 1; RIn = 1; COut = 1;  tick();
        Gra = 1; ROut = 1;
        out_chk(name, exp);
    endtask

    task automatic branch_seq(logic take, logic exp_con);
        drive_port(32'd342); PCIn = 1; tick();
        fetch();
        PCOut = 1;  out_chk("fetch_pc", 32'd343);
        COut = 1;   out_chk("fetch_ir_c", 32'd35);
        Gra = 1; ROut = 1; Conin = 1; tick();
        expect_eq("branch_con", {31'd0, ConOut}, {31'd0, exp_con});
        PCOut = 1; YIn = 1;                 tick();
        COut = 1; ZIn = 1; ALUCode = 5'd3;  tick();
        ZLoOut = 1; out_chk("branch_target", 32'd378);
        if (take) begin
            ZLoOut = 1; PCIn = 1; tick();
        end
        PCOut = 1;
        out_chk("branch_pc", take ? 32'd378 : 32'd343);
    endtask

    typedef struct {
        logic [4:0]  code;
        logic [31:0] lo;
    } alu_vec_t;

    // Y = 0x80000F0F, bus = 0x24 (shift/rotate amount 4)
    alu_vec_t alu_tab [14] = '{
        '{5'd3,  32'h80000F33}, '{5'd4,  32'h80000EEB}, '{5'd5,  32'h00000004},
        '{5'd6,  32'h80000F2F}, '{5'd7,  32'h080000F0}, '{5'd8,  32'hF80000F0},
        '{5'd9,  32'h0000F0F0}, '{5'd10, 32'hF80000F0}, '{5'd11, 32'h0000F0F8},
        '{5'd16, 32'hFFFFFFDC}, '{5'd17, 32'hFFFFFFDB}, '{5'd31, 32'h00000025},
        '{5'd0,  32'h00000000}, '{5'd12, 32'h00000000}
    };

    // ---------------- stimulus ----------------
    initial begin
        clr_ctl();
        clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;
        run   = 1'b1;

        // ---- asynchronous reset ----
        drive_port(32'd5); PCIn = 1;        tick();
        PCOut = 1; ZIn = 1; ALUCode = 5'd31; tick();   // Z = 6
        Conin = 1;                           tick();   // IR = 0, C2 = 00, bus 0 -> 1
        PCOut = 1; out_chk("pre_reset_pc", 32'd5);
        expect_eq("pre_reset_con", {31'd0, ConOut}, 32'd1);
        #2;
        clear = 1'b0;
        #1;
        expect_eq("async_reset_outport", OutPort, 32'd0);
        expect_eq("async_reset_con", {31'd0, ConOut}, 32'd0);
        @(posedge clock);
        #1;
        clear = 1'b1;
        drive_port(32'h77); out_chk("post_reset_port", 32'h77);
        ZLoOut = 1;         out_chk("post_reset_z", 32'd0);
        PCOut = 1; ZIn = 1; ALUCode = 5'd31; tick();
        ZLoOut = 1;         out_chk("post_reset_pc_inc", 32'd1);

        // ---- constant loads ----
        const_load("const_pos", 32'h0080000F, 32'h0000000F);
        const_load("const_neg", 32'h0087FFFF, 32'hFFFFFFFF);

        // ---- taken branch ----
        drive_port(32'd342); MARIn = 1;          tick();
        drive_port(32'h90880023); initMem = 1;   tick();
        const_load("branch_r1", 32'h0080000F, 32'h0000000F);
        branch_seq(1'b1, 1'b1);

        // ---- not-taken branch (IR still holds the branch, Ra = 1) ----
        drive_port(32'd0); Gra = 1; RIn = 1; tick();
        branch_seq(1'b0, 1'b0);

        // ---- C2 = 11 ----
        drive_port(32'h00180000); IRIn = 1;  tick();
        drive_port(32'h80000000); Conin = 1; tick();
        expect_eq("c2_neg_set", {31'd0, ConOut}, 32'd1);
        drive_port(32'h7FFFFFFF); Conin = 1; tick();
        expect_eq("c2_pos_clr", {31'd0, ConOut}, 32'd0);

        // ---- multiply / divide ----
        drive_port(32'hFFFFFFFD); YIn = 1;                tick();
        drive_port(32'd7); ZIn = 1; ALUCode = 5'd14;      tick();
        ZLoOut = 1; out_chk("mul_lo", 32'hFFFFFFEB);
        ZHiOut = 1; out_chk("mul_hi", 32'hFFFFFFFF);
        drive_port(32'd17); YIn = 1;                      tick();
        drive_port(32'd5); ZIn = 1; ALUCode = 5'd15;      tick();
        ZLoOut = 1; out_chk("div_quo", 32'd3);
        ZHiOut = 1; out_chk("div_rem", 32'd2);
        drive_port(32'd0); ZIn = 1; ALUCode = 5'd15;      tick();
        ZLoOut = 1; out_chk("div0_lo", 32'd0);
        ZHiOut = 1; out_chk("div0_hi", 32'd0);

        // ---- single-word ALU sweep ----
        drive_port(32'h80000F0F); YIn = 1; tick();
        foreach (alu_tab[i]) begin
            drive_port(32'h24); ZIn = 1; ALUCode = alu_tab[i].code; tick();
            ZLoOut = 1; out_chk($sformatf("alu_lo_%0d", alu_tab[i].code), alu_tab[i].lo);
            ZHiOut = 1; out_chk($sformatf("alu_hi_%0d", alu_tab[i].code), 32'd0);
        end

        // ---- memory and port ----
        drive_port(32'd100); MARIn = 1;       tick();
        drive_port(32'hDEADBEEF); MDRIn = 1;  tick();
        memwrite = 1;                         tick();
        drive_port(32'd0); MDRIn = 1;         tick();
        memread = 1; MDRIn = 1;               tick();
        MDROut = 1; out_chk("mem_rd_100", 32'hDEADBEEF);
        drive_port(32'd101); MARIn = 1;       tick();
        drive_port(32'h1234); initMem = 1;    tick();
        memread = 1; MDRIn = 1;               tick();
        MDROut = 1; out_chk("initmem_101", 32'h1234);
        // write and read of the same word on one edge returns the old word
        drive_port(32'd100); MARIn = 1;       tick();
        drive_port(32'h55); MDRIn = 1;        tick();
        memwrite = 1; memread = 1; MDRIn = 1; tick();
        MDROut = 1; out_chk("rw_same_edge_old", 32'hDEADBEEF);
        memread = 1; MDRIn = 1;               tick();
        MDROut = 1; out_chk("rw_same_edge_new", 32'h55);
        drive_port(32'hA5); out_chk("oport_a5", 32'hA5);

        // ---- bus priority, Hi/Lo, R0 base address ----
        drive_port(32'h11); MDROut = 1; out_chk("prio_iport_mdr", 32'h11);
        COut = 1; MDROut = 1; PCOut = 1; out_chk("prio_cout_mdr", 32'h0);
        drive_port(32'h99); RIn = 1;    tick();   // no Gr* -> R0
        ROut = 1;  out_chk("r0_rout", 32'h99);
        BAOut = 1; out_chk("r0_baout", 32'h0);
        drive_port(32'h1111); HiIn = 1; tick();
        drive_port(32'h2222); LoIn = 1; tick();
        HiOut = 1; LoOut = 1; out_chk("prio_hi_lo", 32'h1111);
        LoOut = 1;            out_chk("lo_reg", 32'h2222);
        out_chk("bus_idle_zero", 32'h0);

        tick();
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
